// File: rtl/ct_mux_arb.sv
// Round-robin packet arbiter driving a downstream mux select; grant lands 1 cycle after request.
// The grant is held for the whole packet and released on an eop transfer; the downstream ready is steered back to the owner only.
module ct_mux_arb #(
  parameter int NI   = 4,
  parameter int SELW = $clog2(NI)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NI-1:0]   i_valid,
  input  logic [NI-1:0]   i_eop,
  output logic [NI-1:0]   o_ready,
  input  logic            i_ready,
  output logic [NI-1:0]   o_grant,
  output logic [SELW-1:0] o_sel,
  output logic            o_valid,
  output logic            o_eop
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [NI-1:0]   r_grant;
  logic [NI-1:0]   w_next_grant;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] w_next_sel;
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_next_ptr;

  logic            w_found;
  logic [SELW-1:0] w_win;
  logic [SELW-1:0] w_cand;
  logic [NI-1:0]   w_win_oh;
  logic            w_locked;
  logic            w_xfer;

  // Search starts just past the last winner so every requester gets its turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = '0;
    for (int k = 1; k <= NI; k++) begin
      w_cand = SELW'((int'(r_ptr) + k) % NI);
      if (!w_found && i_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  assign w_locked = (r_state == S_LOCKED);
  assign o_valid  = w_locked & i_valid[r_sel];
  assign o_eop    = w_locked & i_eop[r_sel];
  assign w_xfer   = o_valid & i_ready;
  assign o_grant  = r_grant;
  assign o_sel    = r_sel;

  always_comb begin
    o_ready = '0;
    if (w_locked) begin
      o_ready[r_sel] = i_ready;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    w_next_sel   = r_sel;
    w_next_ptr   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next_state = S_LOCKED;
          w_next_grant = w_win_oh;
          w_next_sel   = w_win;
          w_next_ptr   = w_win;
        end
      end
      S_LOCKED: begin
        // o_sel is left alone on release; only the grant drops.
        if (w_xfer && o_eop) begin
          w_next_state = S_IDLE;
          w_next_grant = '0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_grant = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= SELW'(NI - 1);
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
      r_sel   <= w_next_sel;
      r_ptr   <= w_next_ptr;
    end
  end

endmodule

// File: tb/tb_ct_mux_arb.sv
// Bench for ct_mux_arb: directed packet scenarios plus a randomized run against a packet-level arbiter model.
module tb_ct_mux_arb;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NI-1:0] i_valid = '0;
  logic [NI-1:0] i_eop = '0;
  logic          i_ready = 1'b0;
  logic [NI-1:0] o_ready;
  logic [NI-1:0] o_grant;
  logic [1:0]    o_sel;
  logic          o_valid;
  logic          o_eop;

  int checks = 0;
  int failures = 0;

  // Packet-level model: who owns the output, and who won last.
  logic       m_locked = 1'b0;
  logic [1:0] m_sel = 2'd0;
  logic [1:0] m_ptr = 2'd3;
  logic       ev_grant;
  logic [1:0] ev_winner;

  ct_mux_arb #(.NI(NI), .SELW(2)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_eop(i_eop), .o_ready(o_ready),
    .i_ready(i_ready), .o_grant(o_grant), .o_sel(o_sel), .o_valid(o_valid), .o_eop(o_eop)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic set_in(input logic [NI-1:0] v, input logic [NI-1:0] e, input logic r);
    i_valid = v;
    i_eop   = e;
    i_ready = r;
    #1;
  endtask

  // Advance one clock and move the model forward from the inputs the DUT just sampled.
  task automatic tick();
    logic [1:0] idx;
    @(posedge clk);
    ev_grant  = 1'b0;
    ev_winner = 2'd0;
    if (reset) begin
      m_locked = 1'b0;
      m_sel    = 2'd0;
      m_ptr    = 2'(NI - 1);
    end else if (!m_locked) begin
      for (int k = 1; k <= NI; k++) begin
        idx = m_ptr + 2'(k);
        if (!ev_grant && i_valid[idx]) begin
          ev_grant  = 1'b1;
          ev_winner = idx;
        end
      end
      if (ev_grant) begin
        m_locked = 1'b1;
        m_sel    = ev_winner;
        m_ptr    = ev_winner;
      end
    end else if (i_valid[m_sel] && i_ready && i_eop[m_sel]) begin
      m_locked = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in('0, '0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(4'hF, 4'hF, 1'b1);
    tick();
    tick();
    set_in(4'hF, 4'hF, 1'b1);
    checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: o_grant=%b want 0000", o_grant); end
    checks++; if (o_sel !== 2'd0) begin failures++; $display("FAIL reset_sel: o_sel=%0d want 0", o_sel); end
    checks++; if (o_valid !== 1'b0 || o_eop !== 1'b0) begin failures++; $display("FAIL reset_valid_eop: o_valid=%b o_eop=%b want 0 0", o_valid, o_eop); end
    checks++; if (o_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: o_ready=%b want 0000", o_ready); end
    reset = 1'b0;
    set_in(4'hF, 4'h0, 1'b1);
    checks++; if (o_valid !== 1'b0 || o_ready !== 4'b0000) begin failures++; $display("FAIL idle_outputs: o_valid=%b o_ready=%b want 0 0000", o_valid, o_ready); end
    tick();
    set_in(4'hF, 4'h0, 1'b1);
    checks++; if (o_grant !== 4'b0001 || o_sel !== 2'd0) begin failures++; $display("FAIL reset_priority: o_grant=%b o_sel=%0d want 0001 0", o_grant, o_sel); end
  endtask

  task automatic test_basic_packet();
    do_reset();
    set_in(4'b1010, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b0000 || o_valid !== 1'b0) begin failures++; $display("FAIL basic_idle: o_grant=%b o_valid=%b want 0000 0", o_grant, o_valid); end
    tick();
    for (int b = 0; b < 3; b++) begin
      set_in(4'b1010, (b == 2) ? 4'b0010 : 4'b0000, 1'b1);
      checks++; if (o_grant !== 4'b0010 || o_sel !== 2'd1) begin failures++; $display("FAIL basic_grant beat%0d: o_grant=%b o_sel=%0d want 0010 1", b, o_grant, o_sel); end
      checks++; if (o_valid !== 1'b1 || o_ready !== 4'b0010 || o_eop !== (b == 2)) begin failures++; $display("FAIL basic_beat%0d: o_valid=%b o_ready=%b o_eop=%b want 1 0010 %0d", b, o_valid, o_ready, o_eop, b == 2); end
      tick();
    end
    set_in(4'b1010, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b0000 || o_sel !== 2'd1 || o_ready !== 4'b0000) begin failures++; $display("FAIL basic_bubble: o_grant=%b o_sel=%0d o_ready=%b want 0000 1 0000", o_grant, o_sel, o_ready); end
    tick();
    set_in(4'b1010, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b1000 || o_sel !== 2'd3) begin failures++; $display("FAIL basic_second_grant: o_grant=%b o_sel=%0d want 1000 3", o_grant, o_sel); end
  endtask

  task automatic test_back_to_back();
    logic       xfer;
    logic [1:0] es;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_in(4'hF, 4'hF, 1'b1);
      xfer = o_valid && i_ready;
      checks++; if (xfer !== (c % 2 == 1)) begin failures++; $display("FAIL b2b_xfer cyc%0d: xfer=%b want %0d", c, xfer, c % 2 == 1); end
      if (c % 2 == 1) begin
        es = 2'((c / 2) % 4);
        checks++; if (o_sel !== es) begin failures++; $display("FAIL b2b_order cyc%0d: o_sel=%0d want %0d", c, o_sel, es); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(4'b0100, 4'b0000, 1'b1);
    tick();
    set_in(4'b0100, 4'b0000, 1'b1);
    checks++; if (o_valid !== 1'b1 || o_ready !== 4'b0100) begin failures++; $display("FAIL stall_first_beat: o_valid=%b o_ready=%b want 1 0100", o_valid, o_ready); end
    tick();
    for (int s = 0; s < 5; s++) begin
      set_in(4'b0111, 4'b0100, 1'b0);
      checks++; if (o_grant !== 4'b0100 || o_ready !== 4'b0000) begin failures++; $display("FAIL stall_hold%0d: o_grant=%b o_ready=%b want 0100 0000", s, o_grant, o_ready); end
      tick();
    end
    set_in(4'b0111, 4'b0100, 1'b1);
    checks++; if (o_eop !== 1'b1 || o_ready !== 4'b0100 || o_grant !== 4'b0100) begin failures++; $display("FAIL stall_eop: o_eop=%b o_ready=%b o_grant=%b want 1 0100 0100", o_eop, o_ready, o_grant); end
    tick();
    set_in(4'b0111, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b0000 || o_ready !== 4'b0000) begin failures++; $display("FAIL stall_release: o_grant=%b o_ready=%b want 0000 0000", o_grant, o_ready); end
    tick();
    set_in(4'b0111, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b0001) begin failures++; $display("FAIL stall_next_rr: o_grant=%b want 0001", o_grant); end
  endtask

  task automatic test_valid_gap();
    do_reset();
    set_in(4'b0010, 4'b0000, 1'b1);
    tick();
    set_in(4'b0010, 4'b0000, 1'b1);
    checks++; if (o_valid !== 1'b1 || o_grant !== 4'b0010) begin failures++; $display("FAIL gap_first_beat: o_valid=%b o_grant=%b want 1 0010", o_valid, o_grant); end
    tick();
    for (int g = 0; g < 3; g++) begin
      set_in(4'b0001, 4'b0001, 1'b1);
      checks++; if (o_grant !== 4'b0010 || o_valid !== 1'b0 || o_eop !== 1'b0) begin failures++; $display("FAIL gap_hold%0d: o_grant=%b o_valid=%b o_eop=%b want 0010 0 0", g, o_grant, o_valid, o_eop); end
      tick();
    end
    set_in(4'b0011, 4'b0010, 1'b1);
    checks++; if (o_eop !== 1'b1 || o_valid !== 1'b1) begin failures++; $display("FAIL gap_eop: o_eop=%b o_valid=%b want 1 1", o_eop, o_valid); end
    tick();
    set_in(4'b0001, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL gap_release: o_grant=%b want 0000", o_grant); end
    tick();
    set_in(4'b0001, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b0001 || o_sel !== 2'd0) begin failures++; $display("FAIL gap_next: o_grant=%b o_sel=%0d want 0001 0", o_grant, o_sel); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_in(4'b1000, 4'b0000, 1'b1);
    tick();
    set_in(4'b1000, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b1000 || o_sel !== 2'd3) begin failures++; $display("FAIL rstmid_grant: o_grant=%b o_sel=%0d want 1000 3", o_grant, o_sel); end
    tick();
    reset = 1'b1;
    set_in(4'b1001, 4'b0000, 1'b1);
    tick();
    reset = 1'b0;
    set_in(4'b1001, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b0000 || o_sel !== 2'd0 || o_ready !== 4'b0000 || o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_abort: o_grant=%b o_sel=%0d o_ready=%b o_valid=%b want 0000 0 0000 0", o_grant, o_sel, o_ready, o_valid); end
    tick();
    set_in(4'b1001, 4'b0000, 1'b1);
    checks++; if (o_grant !== 4'b0001) begin failures++; $display("FAIL rstmid_regrant: o_grant=%b want 0001", o_grant); end
  endtask

  task automatic test_random();
    bit            pending[NI];
    int            waited[NI];
    logic [NI-1:0] v, e, eg, er;
    logic          r;
    do_reset();
    for (int i = 0; i < NI; i++) begin
      pending[i] = 1'b0;
      waited[i]  = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        if (m_locked && m_sel == 2'(i)) begin
          v[i] = ($urandom_range(9) < 7);
          e[i] = v[i] && ($urandom_range(2) == 0);
        end else begin
          if (!pending[i] && $urandom_range(3) == 0) pending[i] = 1'b1;
          v[i] = pending[i];
          e[i] = 1'($urandom_range(1));
        end
      end
      r = ($urandom_range(3) != 0);
      set_in(v, e, r);
      eg = m_locked ? (4'b0001 << m_sel) : 4'b0000;
      er = (m_locked && r) ? (4'b0001 << m_sel) : 4'b0000;
      checks++; if (!$onehot0(o_grant)) begin failures++; $display("FAIL rnd_onehot cyc%0d: o_grant=%b want zero or one-hot", cyc, o_grant); end
      checks++; if (o_grant !== eg) begin failures++; $display("FAIL rnd_grant cyc%0d: o_grant=%b want %b", cyc, o_grant, eg); end
      if (m_locked) begin
        checks++; if (o_sel !== m_sel) begin failures++; $display("FAIL rnd_sel cyc%0d: o_sel=%0d want %0d", cyc, o_sel, m_sel); end
      end
      checks++; if (o_valid !== (m_locked && v[m_sel])) begin failures++; $display("FAIL rnd_valid cyc%0d: o_valid=%b want %0d", cyc, o_valid, m_locked && v[m_sel]); end
      checks++; if (o_eop !== (m_locked && e[m_sel])) begin failures++; $display("FAIL rnd_eop cyc%0d: o_eop=%b want %0d", cyc, o_eop, m_locked && e[m_sel]); end
      checks++; if (o_ready !== er) begin failures++; $display("FAIL rnd_ready cyc%0d: o_ready=%b want %b", cyc, o_ready, er); end
      tick();
      if (ev_grant) begin
        checks++; if (waited[ev_winner] > NI - 1) begin failures++; $display("FAIL rnd_starve cyc%0d: requester %0d waited %0d grants, want <= %0d", cyc, ev_winner, waited[ev_winner], NI - 1); end
        pending[ev_winner] = 1'b0;
        waited[ev_winner]  = 0;
        for (int i = 0; i < NI; i++) begin
          if (pending[i] && 2'(i) != ev_winner) waited[i]++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_back_to_back();
    test_stall();
    test_valid_gap();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ct_mux_arb.md
CT_MUX_ARB -- requirements
Module: ct_mux_arb

Interface
REQ-001 The block SHALL have parameter NI, default 4, giving the number of requesters (2..32).
REQ-002 The block SHALL have parameter SELW, default 2, giving the select width, equal to clog2(NI).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port i_valid, input, NI: per-requester valid/request.
REQ-006 Port i_eop, input, NI: per-requester end-of-packet flag, qualified by i_valid.
REQ-007 Port o_ready, output, NI: per-requester ready.
REQ-008 Port i_ready, input, 1: downstream ready.
REQ-009 Port o_grant, output, NI: one-hot grant, registered.
REQ-010 Port o_sel, output, SELW: binary index of the granted requester, registered; drives the downstream mux select.
REQ-011 Port o_valid, output, 1: downstream valid.
REQ-012 Port o_eop, output, 1: downstream end-of-packet.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and LOCKED.
REQ-014 In IDLE with any i_valid bit set, the block SHALL pick a winner by round-robin.
  - Search order: index ptr+1, ptr+2, ... wrapping modulo NI; the first set bit wins.
  - At the next edge: o_grant = one-hot(winner), o_sel = winner, ptr = winner, state = LOCKED.
REQ-015 In IDLE with i_valid all zero, state, ptr, o_grant and o_sel SHALL hold.
REQ-016 Arbitration latency SHALL be exactly 1 cycle: a request seen in IDLE at edge t gives a grant visible after edge t.
REQ-017 In LOCKED, o_grant and o_sel SHALL hold constant until release.
REQ-018 In LOCKED, the output terms SHALL be combinational from registered o_sel:
  - o_valid = i_valid[o_sel]
  - o_eop = i_eop[o_sel]
  - o_ready[o_sel] = i_ready; all other o_ready bits = 0
REQ-019 In IDLE, o_valid, o_eop and all o_ready bits SHALL be 0; no transfer occurs in IDLE.
REQ-020 A transfer SHALL be defined as a cycle in LOCKED with o_valid && i_ready.
REQ-021 Release: a transfer with o_eop = 1 SHALL cause the next state to be IDLE with o_grant = 0.
  - o_sel holds its last value.
  - One bubble cycle follows every packet.
REQ-022 A transfer with o_eop = 0 SHALL NOT release the lock.
REQ-023 Deassertion of i_valid[o_sel] mid-packet SHALL NOT release the lock; the grant is held until an eop transfer.
REQ-024 Single-beat packets (valid and eop in the same beat) SHALL lock for exactly one transfer, then release.
REQ-025 A requester with a continuous request SHALL be granted within NI arbitration rounds (starvation-free).
REQ-026 If only the previous winner requests in IDLE, it SHALL be re-granted.
REQ-027 o_grant SHALL always be zero or one-hot, and nonzero only in LOCKED.

Reset
REQ-028 While reset = 1 at an edge, the block SHALL set:
  - state = IDLE
  - o_grant = 0
  - o_sel = 0
  - ptr = NI-1, so that requester 0 has highest priority first
REQ-029 Reset asserted mid-packet SHALL abort the lock with no further transfer; o_ready SHALL be 0 in the cycle after the reset edge.
REQ-030 Reset SHALL take priority over any simultaneous release or arbitration.

Verification
REQ-031 NI=4, after reset: i_valid=4'b1010 -> after 1 cycle o_grant=4'b0010, o_sel=1; a 3-beat packet with i_ready=1 passes; IDLE for 1 cycle; then o_grant=4'b1000, o_sel=3.
REQ-032 All four requesters continuously valid with single-beat packets -> grant order 0,1,2,3,0; exactly one transfer every 2 cycles.
REQ-033 Granted requester 2 mid-packet with i_ready=0 for 5 cycles -> o_grant=4'b0100 holds, o_ready=0, no release; eop transfer with i_ready=1 -> IDLE next cycle.
REQ-034 Granted requester 1 drops i_valid for 3 cycles mid-packet while requester 0 is valid -> o_grant stays 4'b0010 and o_valid=0 during the gap; requester 0 is granted only after requester 1's eop.
REQ-035 Reset pulsed during a LOCKED packet from requester 3 -> next cycle o_grant=0, o_sel=0, o_ready=0; with i_valid=4'b1001 the next grant is to requester 0.
REQ-036 Random valid/eop/ready stimulus over 10k cycles -> scoreboard checks: o_grant is zero or one-hot; no packet interleaving on the output; every waiting requester is granted within 4 packets.
